// File: rtl/stream_rr_arbiter.sv
// ---------------------------------------------------------------------------------------------
// stream_rr_arbiter
//
// Four-requester round-robin stream arbiter with a registered output slice. A requester holds
// the grant for up to MAX_BURST accepted beats, or until it drops its valid. It then releases
// to IDLE for one cycle before the next arbitration. The next winner is the first valid
// requester found by searching cyclically from the last granted index plus one.
//
// Parameters
//   MAX_BURST   beats accepted per grant before rotation (1..15)
//
// Ports
//   clk_i        clock; all state updates on its rising edge
//   arstn_i      asynchronous active-low reset
//   s_tvalid_i   per-requester valid, bit k = requester k
//   s_tready_o   per-requester ready; depends only on registers and m_tready_i
//   s_tdata_i    per-requester data, requester k on bits [4k+3:4k]
//   m_tvalid_o   registered output valid
//   m_tready_i   downstream ready
//   m_tdata_o    registered output data
//   m_tid_o      source index of the m_tdata_o beat (only when ARB_TID_EN is defined)
//   grant_o      one-hot current grant, zero while idle
//
// Build option
//   ARB_TID_EN   when defined, adds the m_tid_o port and its register
// ---------------------------------------------------------------------------------------------

module stream_rr_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic [3:0]  s_tvalid_i,
  output logic [3:0]  s_tready_o,
  input  logic [15:0] s_tdata_i,
  output logic        m_tvalid_o,
  input  logic        m_tready_i,
  output logic [3:0]  m_tdata_o,
`ifdef ARB_TID_EN
  output logic [1:0]  m_tid_o,
`endif
  output logic [3:0]  grant_o
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  localparam logic [3:0] MaxBurstCnt = 4'(MAX_BURST);

  state_e      state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic [1:0]  gidx_q, gidx_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        m_tvalid_q, m_tvalid_d;
  logic [3:0]  m_tdata_q, m_tdata_d;
`ifdef ARB_TID_EN
  logic [1:0]  m_tid_q, m_tid_d;
`endif

  logic        out_free;
  logic        accept;
  logic        gvalid;
  logic [3:0]  lane_data;
  logic        pick_found;
  logic [1:0]  pick_idx;
  logic [1:0]  cand;

  // The output slice can take a new beat when empty or draining this cycle. grant_q is
  // one-hot or zero, so at most one ready bit is ever set.
  assign out_free   = ~m_tvalid_q | m_tready_i;
  assign s_tready_o = grant_q & {4{out_free}};
  assign accept     = |(s_tvalid_i & s_tready_o);
  assign gvalid     = s_tvalid_i[gidx_q];
  assign lane_data  = s_tdata_i[{gidx_q, 2'b00} +: 4];

  // Cyclic priority search starting just after the last winner; the last winner itself is
  // the final candidate (i = 4 wraps back onto it).
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_grant_q;
    cand       = '0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_grant_q + 2'(i);
      if (!pick_found && s_tvalid_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Grant FSM next state. Release always lands in StIdle, which guarantees a one-cycle
  // bubble between consecutive grants.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gidx_d       = gidx_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d = StBusy;
          grant_d = 4'b0001 << pick_idx;
          gidx_d  = pick_idx;
          cnt_d   = '0;
        end
      end
      StBusy: begin
        if (accept) begin
          cnt_d = cnt_q + 4'd1;
        end
        // Backpressure alone never releases: only a dropped valid or a full burst does.
        if (!gvalid || (accept && (cnt_q + 4'd1 == MaxBurstCnt))) begin
          state_d      = StIdle;
          grant_d      = '0;
          last_grant_d = gidx_q;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  // Output register slice: load on accept, otherwise clear once the downstream takes the beat.
  always_comb begin
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
`ifdef ARB_TID_EN
    m_tid_d    = m_tid_q;
`endif
    if (accept) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = lane_data;
`ifdef ARB_TID_EN
      m_tid_d    = gidx_q;
`endif
    end else if (m_tready_i) begin
      m_tvalid_d = 1'b0;
    end
  end

  // last_grant resets to 3 so that requester 0 wins the first arbitration.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      gidx_q       <= '0;
      last_grant_q <= 2'd3;
      cnt_q        <= '0;
      m_tvalid_q   <= 1'b0;
      m_tdata_q    <= '0;
`ifdef ARB_TID_EN
      m_tid_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      gidx_q       <= gidx_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tdata_q    <= m_tdata_d;
`ifdef ARB_TID_EN
      m_tid_q      <= m_tid_d;
`endif
    end
  end

  assign grant_o    = grant_q;
  assign m_tvalid_o = m_tvalid_q;
  assign m_tdata_o  = m_tdata_q;
`ifdef ARB_TID_EN
  assign m_tid_o    = m_tid_q;
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter: one instance with MAX_BURST=4 (a_*) and one with
// MAX_BURST=1 (b_*), sharing clock, reset and input stimulus.

module tb_stream_rr_arbiter;

  logic        clk;
  logic        arstn;
  logic [3:0]  s_tvalid;
  logic [15:0] s_tdata;
  logic        m_tready;

  logic [3:0]  a_s_tready, a_grant, a_m_tdata;
  logic        a_m_tvalid;
  logic [3:0]  b_s_tready, b_grant, b_m_tdata;
  logic        b_m_tvalid;
`ifdef ARB_TID_EN
  logic [1:0]  a_m_tid, b_m_tid;
`endif

  int n_checks = 0;
  int n_errors = 0;

  stream_rr_arbiter #(.MAX_BURST(4)) u_dut_a (
    .clk_i      (clk),
    .arstn_i    (arstn),
    .s_tvalid_i (s_tvalid),
    .s_tready_o (a_s_tready),
    .s_tdata_i  (s_tdata),
    .m_tvalid_o (a_m_tvalid),
    .m_tready_i (m_tready),
    .m_tdata_o  (a_m_tdata),
`ifdef ARB_TID_EN
    .m_tid_o    (a_m_tid),
`endif
    .grant_o    (a_grant)
  );

  stream_rr_arbiter #(.MAX_BURST(1)) u_dut_b (
    .clk_i      (clk),
    .arstn_i    (arstn),
    .s_tvalid_i (s_tvalid),
    .s_tready_o (b_s_tready),
    .s_tdata_i  (s_tdata),
    .m_tvalid_o (b_m_tvalid),
    .m_tready_i (m_tready),
    .m_tdata_o  (b_m_tdata),
`ifdef ARB_TID_EN
    .m_tid_o    (b_m_tid),
`endif
    .grant_o    (b_grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] eg;
    logic       ev;
    logic [3:0] ed;
    logic [1:0] et;

    arstn    = 1'b0;
    s_tvalid = '0;
    s_tdata  = '0;
    m_tready = 1'b1;

    // Reset state
    #3;
    chk("rst_grant",   16'(a_grant),    16'h0);
    chk("rst_sready",  16'(a_s_tready), 16'h0);
    chk("rst_mvalid",  16'(a_m_tvalid), 16'h0);
    chk("rst_mdata",   16'(a_m_tdata),  16'h0);
    @(posedge clk);
    #3 arstn = 1'b1;
    step();

    // Single requester 2, data 0xA: grant at cycle 1, beat out at cycle 2
    s_tvalid = 4'b0100;
    s_tdata  = 16'h0A00;
    chk("r2_c0_grant", 16'(a_grant), 16'h0);
    step();
    chk("r2_c1_grant",  16'(a_grant),    16'b0100);
    chk("r2_c1_sready", 16'(a_s_tready), 16'b0100);
    chk("r2_c1_mvalid", 16'(a_m_tvalid), 16'h0);
    step();
    chk("r2_c2_mvalid", 16'(a_m_tvalid), 16'h1);
    chk("r2_c2_mdata",  16'(a_m_tdata),  16'hA);
`ifdef ARB_TID_EN
    chk("r2_c2_mtid",   16'(a_m_tid),    16'h2);
`endif
    s_tvalid = 4'b0000;
    step();
    chk("r2_c3_grant",  16'(a_grant),    16'h0);
    chk("r2_c3_mvalid", 16'(a_m_tvalid), 16'h0);

    // Requester 1 streams 3,5,7 with three cycles of backpressure after the first beat
    s_tvalid = 4'b0010;
    s_tdata  = 16'h0030;
    step();
    chk("bp_c1_grant", 16'(a_grant), 16'b0010);
    step();
    chk("bp_c2_mdata", 16'(a_m_tdata), 16'h3);
    m_tready = 1'b0;
    s_tdata  = 16'h0050;
    #1;
    chk("bp_c2_sready", 16'(a_s_tready), 16'h0);
    for (int c = 3; c <= 4; c++) begin
      step();
      chk("bp_hold_mvalid", 16'(a_m_tvalid), 16'h1);
      chk("bp_hold_mdata",  16'(a_m_tdata),  16'h3);
      chk("bp_hold_grant",  16'(a_grant),    16'b0010);
      chk("bp_hold_sready", 16'(a_s_tready), 16'h0);
    end
    step();
    chk("bp_c5_mdata", 16'(a_m_tdata), 16'h3);
    chk("bp_c5_grant", 16'(a_grant),   16'b0010);
    m_tready = 1'b1;
    step();
    chk("bp_c6_mvalid", 16'(a_m_tvalid), 16'h1);
    chk("bp_c6_mdata",  16'(a_m_tdata),  16'h5);
    s_tdata = 16'h0070;
    step();
    chk("bp_c7_mdata", 16'(a_m_tdata), 16'h7);
    s_tvalid = 4'b0000;
    step();
    chk("bp_c8_mvalid", 16'(a_m_tvalid), 16'h0);
    chk("bp_c8_grant",  16'(a_grant),    16'h0);

    // Burst from requester 2 interrupted by reset while the output beat is stalled
    s_tvalid = 4'b0100;
    s_tdata  = 16'h0900;
    step();
    chk("rm_c1_grant", 16'(a_grant), 16'b0100);
    step();
    chk("rm_c2_mvalid", 16'(a_m_tvalid), 16'h1);
    chk("rm_c2_mdata",  16'(a_m_tdata),  16'h9);
    m_tready = 1'b0;
    #1 arstn = 1'b0;
    #1;
    chk("rm_grant",  16'(a_grant),    16'h0);
    chk("rm_sready", 16'(a_s_tready), 16'h0);
    chk("rm_mvalid", 16'(a_m_tvalid), 16'h0);
    chk("rm_mdata",  16'(a_m_tdata),  16'h0);
    s_tvalid = 4'b1001;
    s_tdata  = 16'h8001;
    m_tready = 1'b1;
    #2 arstn = 1'b1;
    #1;
    chk("rm_rel_grant",  16'(a_grant),    16'h0);
    chk("rm_rel_mvalid", 16'(a_m_tvalid), 16'h0);

    // After reset requester 0 wins; it drops valid after 2 beats and requester 3 follows
    step();
    chk("dr_c1_grant",  16'(a_grant),    16'b0001);
    chk("dr_c1_sready", 16'(a_s_tready), 16'b0001);
    step();
    chk("dr_c2_mdata", 16'(a_m_tdata), 16'h1);
    s_tdata = 16'h8002;
    step();
    chk("dr_c3_mdata", 16'(a_m_tdata), 16'h2);
    chk("dr_c3_grant", 16'(a_grant),   16'b0001);
    s_tvalid = 4'b1000;
    step();
    chk("dr_c4_grant",  16'(a_grant),    16'h0);
    chk("dr_c4_mvalid", 16'(a_m_tvalid), 16'h0);
    step();
    chk("dr_c5_grant", 16'(a_grant), 16'b1000);
    step();
    chk("dr_c6_mvalid", 16'(a_m_tvalid), 16'h1);
    chk("dr_c6_mdata",  16'(a_m_tdata),  16'h8);
    s_tvalid = 4'b0000;
    step();
    chk("dr_c7_grant", 16'(a_grant), 16'h0);

    // All four valid, lane k carries k+1: bursts of 4 with a one-cycle bubble between them
    s_tvalid = 4'b1111;
    s_tdata  = 16'h4321;
    for (int c = 1; c <= 25; c++) begin
      step();
      eg = (((c - 1) % 5) < 4) ? 4'(1 << (((c - 1) / 5) % 4)) : 4'b0000;
      ev = (c >= 2) && (((c - 2) % 5) < 4);
      ed = 4'(((c - 2) / 5) % 4 + 1);
      chk("rr_grant",  16'(a_grant),    16'(eg));
      chk("rr_sready", 16'(a_s_tready), 16'(eg));
      chk("rr_mvalid", 16'(a_m_tvalid), 16'(ev));
      if (ev) chk("rr_mdata", 16'(a_m_tdata), 16'(ed));
    end
    s_tvalid = 4'b0000;
    step();
    step();

    // MAX_BURST=1 instance: requesters 1 and 3 alternate one beat per grant
    arstn    = 1'b0;
    s_tvalid = 4'b1010;
    s_tdata  = 16'hC050;
    m_tready = 1'b1;
    #1;
    chk("b_rst_grant",  16'(b_grant),    16'h0);
    chk("b_rst_mvalid", 16'(b_m_tvalid), 16'h0);
    #1 arstn = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      eg = ((c % 2) == 1) ? (((c % 4) == 1) ? 4'b0010 : 4'b1000) : 4'b0000;
      ev = ((c % 2) == 0);
      ed = ((c % 4) == 2) ? 4'h5 : 4'hC;
      et = ((c % 4) == 2) ? 2'd1 : 2'd3;
      chk("mb1_grant",  16'(b_grant),    16'(eg));
      chk("mb1_mvalid", 16'(b_m_tvalid), 16'(ev));
      if (ev) begin
        chk("mb1_mdata", 16'(b_m_tdata), 16'(ed));
`ifdef ARB_TID_EN
        chk("mb1_mtid",  16'(b_m_tid),   16'(et));
`endif
      end
    end
    s_tvalid = 4'b0000;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
